// File: rtl/rv_mem_pkg.sv
// Shared RV32I load/store definitions: funct3 width codes, stage FSM states and
// helpers for access legality and store lane steering.
package rv_mem_pkg;

    localparam logic [2:0] Funct3Lb  = 3'b000;
    localparam logic [2:0] Funct3Lh  = 3'b001;
    localparam logic [2:0] Funct3Lw  = 3'b010;
    localparam logic [2:0] Funct3Lbu = 3'b100;
    localparam logic [2:0] Funct3Lhu = 3'b101;

    localparam logic [2:0] Funct3Sb  = 3'b000;
    localparam logic [2:0] Funct3Sh  = 3'b001;
    localparam logic [2:0] Funct3Sw  = 3'b010;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait
    } mem_state_e;

    // Store codes alias the signed load codes, so one table covers both.
    function automatic logic access_err(input logic       is_load,
                                        input logic [2:0] funct3,
                                        input logic [1:0] addr_lo);
        logic err;
        err = 1'b0;
        case (funct3)
            Funct3Lb:  err = 1'b0;
            Funct3Lh:  err = addr_lo[0];
            Funct3Lw:  err = (addr_lo != 2'b00);
            Funct3Lbu: err = !is_load;
            Funct3Lhu: err = !is_load || addr_lo[0];
            default:   err = 1'b1;
        endcase
        return err;
    endfunction

    // Low two funct3 bits carry the access size for loads and stores alike.
    function automatic logic [3:0] access_be(input logic [2:0] funct3,
                                             input logic [1:0] addr_lo);
        logic [3:0] be;
        case (funct3[1:0])
            2'b00:   be = 4'b0001 << addr_lo;
            2'b01:   be = 4'b0011 << {addr_lo[1], 1'b0};
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0]  funct3,
                                                input logic [31:0] data);
        logic [31:0] lanes;
        case (funct3[1:0])
            2'b00:   lanes = {4{data[7:0]}};
            2'b01:   lanes = {2{data[15:0]}};
            default: lanes = data;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/mem_wb_if.sv
// EX/MEM entry, data-memory port, register-file write port and error pulse of
// the MEM/WB stage. The stage is the slave; its environment is the master.
interface mem_wb_if;

    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic        in_wen;
    logic [31:0] in_result;
    logic        in_load;
    logic        in_store;
    logic [2:0]  in_funct3;
    logic [31:0] in_store_data;

    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    logic        w_regs_en;
    logic [4:0]  w_regs_addr;
    logic [31:0] w_regs_data;
    logic        err_o;

    modport master (
        output in_valid, in_rd, in_wen, in_result, in_load, in_store, in_funct3, in_store_data,
        output dmem_gnt, dmem_rvalid, dmem_rdata,
        input  in_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  w_regs_en, w_regs_addr, w_regs_data, err_o
    );

    modport slave (
        input  in_valid, in_rd, in_wen, in_result, in_load, in_store, in_funct3, in_store_data,
        input  dmem_gnt, dmem_rvalid, dmem_rdata,
        output in_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output w_regs_en, w_regs_addr, w_regs_data, err_o
    );

endinterface

// File: rtl/lsu_load_align.sv
// Combinational load data extraction: selects the addressed byte/halfword of the
// read word and sign- or zero-extends it according to funct3.
module lsu_load_align
    import rv_mem_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[7:0];
        case (addr_lo_i)
            2'b00:   byte_sel = rdata_i[7:0];
            2'b01:   byte_sel = rdata_i[15:8];
            2'b10:   byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        result_o = rdata_i;
        case (funct3_i)
            Funct3Lb:  result_o = {{24{byte_sel[7]}}, byte_sel};
            Funct3Lbu: result_o = {24'd0, byte_sel};
            Funct3Lh:  result_o = {{16{half_sel[15]}}, half_sel};
            Funct3Lhu: result_o = {16'd0, half_sel};
            default:   result_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: ALU results write back in one cycle; loads/stores run a
// req/gnt/rvalid data-memory transaction and stall the upstream meanwhile.
module mem_wb_stage
    import rv_mem_pkg::*;
(
    input logic     clk,
    input logic     rst,
    mem_wb_if.slave bus
);

    mem_state_e  state_q, state_d;
    logic [4:0]  rd_q, rd_d;
    logic        wen_q, wen_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic        is_store_q, is_store_d;
    logic [31:0] dmem_addr_q, dmem_addr_d;
    logic [31:0] dmem_wdata_q, dmem_wdata_d;
    logic [3:0]  dmem_be_q, dmem_be_d;
    logic        w_en_q, w_en_d;
    logic [4:0]  w_addr_q, w_addr_d;
    logic [31:0] w_data_q, w_data_d;
    logic        err_q, err_d;
    logic [31:0] load_data;

    lsu_load_align u_load_align (
        .funct3_i  (funct3_q),
        .addr_lo_i (addr_lo_q),
        .rdata_i   (bus.dmem_rdata),
        .result_o  (load_data)
    );

    always_comb begin
        state_d      = state_q;
        rd_d         = rd_q;
        wen_d        = wen_q;
        funct3_d     = funct3_q;
        addr_lo_d    = addr_lo_q;
        is_store_d   = is_store_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        dmem_be_d    = dmem_be_q;
        w_en_d       = 1'b0;
        w_addr_d     = w_addr_q;
        w_data_d     = w_data_q;
        err_d        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    if (bus.in_load || bus.in_store) begin
                        if (access_err(bus.in_load, bus.in_funct3, bus.in_result[1:0])) begin
                            err_d = 1'b1;
                        end else begin
                            state_d      = StReq;
                            rd_d         = bus.in_rd;
                            wen_d        = bus.in_wen;
                            funct3_d     = bus.in_funct3;
                            addr_lo_d    = bus.in_result[1:0];
                            is_store_d   = bus.in_store;
                            dmem_addr_d  = {bus.in_result[31:2], 2'b00};
                            dmem_be_d    = access_be(bus.in_funct3, bus.in_result[1:0]);
                            dmem_wdata_d = bus.in_store ?
                                           store_lanes(bus.in_funct3, bus.in_store_data) : 32'd0;
                        end
                    end else if (bus.in_wen && (bus.in_rd != 5'd0)) begin
                        w_en_d   = 1'b1;
                        w_addr_d = bus.in_rd;
                        w_data_d = bus.in_result;
                    end
                end
            end
            StReq: begin
                if (bus.dmem_gnt) begin
                    state_d = is_store_q ? StIdle : StWait;
                end
            end
            StWait: begin
                if (bus.dmem_rvalid) begin
                    state_d = StIdle;
                    if (wen_q && (rd_q != 5'd0)) begin
                        w_en_d   = 1'b1;
                        w_addr_d = rd_q;
                        w_data_d = load_data;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StIdle;
            rd_q         <= 5'd0;
            wen_q        <= 1'b0;
            funct3_q     <= 3'd0;
            addr_lo_q    <= 2'd0;
            is_store_q   <= 1'b0;
            dmem_addr_q  <= 32'd0;
            dmem_wdata_q <= 32'd0;
            dmem_be_q    <= 4'd0;
            w_en_q       <= 1'b0;
            w_addr_q     <= 5'd0;
            w_data_q     <= 32'd0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_q         <= rd_d;
            wen_q        <= wen_d;
            funct3_q     <= funct3_d;
            addr_lo_q    <= addr_lo_d;
            is_store_q   <= is_store_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            dmem_be_q    <= dmem_be_d;
            w_en_q       <= w_en_d;
            w_addr_q     <= w_addr_d;
            w_data_q     <= w_data_d;
            err_q        <= err_d;
        end
    end

    // Request qualifiers are gated so we/be never leak outside an active request.
    always_comb begin
        bus.in_ready    = (state_q == StIdle);
        bus.dmem_req    = (state_q == StReq);
        bus.dmem_we     = (state_q == StReq) && is_store_q;
        bus.dmem_be     = (state_q == StReq) ? dmem_be_q : 4'b0000;
        bus.dmem_addr   = dmem_addr_q;
        bus.dmem_wdata  = dmem_wdata_q;
        bus.w_regs_en   = w_en_q;
        bus.w_regs_addr = w_addr_q;
        bus.w_regs_data = w_data_q;
        bus.err_o       = err_q;
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: stimulus pushes expected writebacks/errors into
// a queue; a negedge monitor pops and compares whenever the stage emits one.
module tb_mem_wb_stage;

    typedef struct packed {
        logic        is_err;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic mon_en = 1'b0;
    int   total = 0;
    int   bad = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    mem_wb_if bus ();

    mem_wb_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wb(input logic [4:0] rd, input logic [31:0] data);
        exp_q.push_back('{is_err: 1'b0, rd: rd, data: data});
    endtask

    task automatic push_err();
        exp_q.push_back('{is_err: 1'b1, rd: 5'd0, data: 32'd0});
    endtask

    task automatic drive(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] res, input logic [31:0] sd,
                         input logic [4:0] rd, input logic wen);
        bus.in_valid      = 1'b1;
        bus.in_load       = ld;
        bus.in_store      = st;
        bus.in_funct3     = f3;
        bus.in_result     = res;
        bus.in_store_data = sd;
        bus.in_rd         = rd;
        bus.in_wen        = wen;
    endtask

    task automatic alu_op(input logic [4:0] rd, input logic wen, input logic [31:0] res);
        drive(1'b0, 1'b0, 3'd0, res, 32'd0, rd, wen);
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Issues a legal load/store and walks it through req/gnt(/rvalid).
    task automatic mem_op(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [4:0] rd, input int gnt_wait,
                          input logic [31:0] rdata, input logic [31:0] exp_addr,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata);
        drive(ld, !ld, f3, addr, sdata, rd, ld);
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i <= gnt_wait; i++) begin
            @(negedge clk);
            check("dmem_req_high", 32'(bus.dmem_req), 32'd1);
            check("in_ready_low_req", 32'(bus.in_ready), 32'd0);
            check("dmem_addr", bus.dmem_addr, exp_addr);
            check("dmem_be", 32'(bus.dmem_be), 32'(exp_be));
            check("dmem_we", 32'(bus.dmem_we), 32'(!ld));
            if (!ld) check("dmem_wdata", bus.dmem_wdata, exp_wdata);
            if (i == gnt_wait) bus.dmem_gnt = 1'b1;
            tick();
        end
        bus.dmem_gnt = 1'b0;
        @(negedge clk);
        check("dmem_req_low_after_gnt", 32'(bus.dmem_req), 32'd0);
        check("dmem_be_idle", 32'(bus.dmem_be), 32'd0);
        check("dmem_we_idle", 32'(bus.dmem_we), 32'd0);
        if (ld) begin
            check("in_ready_low_wait", 32'(bus.in_ready), 32'd0);
            bus.dmem_rvalid = 1'b1;
            bus.dmem_rdata  = rdata;
            tick();
            bus.dmem_rvalid = 1'b0;
        end else begin
            check("in_ready_after_store", 32'(bus.in_ready), 32'd1);
        end
    endtask

    task automatic err_op(input logic ld, input logic [2:0] f3, input logic [31:0] addr);
        push_err();
        drive(ld, !ld, f3, addr, 32'h5555_5555, 5'd6, ld);
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("err_no_req", 32'(bus.dmem_req), 32'd0);
        check("err_ready", 32'(bus.in_ready), 32'd1);
        check("err_no_wb", 32'(bus.w_regs_en), 32'd0);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (mon_en && (bus.w_regs_en || bus.err_o)) begin
            if (exp_q.size() == 0) begin
                check("spurious_event", {30'd0, bus.err_o, bus.w_regs_en}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("event_is_err", 32'(bus.err_o), 32'(e.is_err));
                check("event_is_wb", 32'(bus.w_regs_en), 32'(!e.is_err));
                if (!e.is_err) begin
                    check("wb_addr", 32'(bus.w_regs_addr), 32'(e.rd));
                    check("wb_data", bus.w_regs_data, e.data);
                end
            end
        end
    end

    initial begin
        rst = 1'b0;
        bus.in_valid = 1'b0;
        drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        bus.in_valid    = 1'b0;
        bus.dmem_gnt    = 1'b0;
        bus.dmem_rvalid = 1'b0;
        bus.dmem_rdata  = 32'd0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_ready", 32'(bus.in_ready), 32'd1);
        check("rst_req", 32'(bus.dmem_req), 32'd0);
        check("rst_addr", bus.dmem_addr, 32'd0);
        check("rst_wen", 32'(bus.w_regs_en), 32'd0);
        check("rst_err", 32'(bus.err_o), 32'd0);
        rst = 1'b1;
        mon_en = 1'b1;
        tick();

        // ALU writeback, rd=0 suppression, wen=0 suppression
        push_wb(5'd5, 32'h0000_1234);
        alu_op(5'd5, 1'b1, 32'h0000_1234);
        alu_op(5'd0, 1'b1, 32'hDEAD_0000);
        alu_op(5'd3, 1'b0, 32'h0BAD_0BAD);
        tick();

        // Loads: rdata 0x80FF_FF7F
        push_wb(5'd7, 32'hFFFF_FF80);
        mem_op(1'b1, 3'b000, 32'h0000_0103, 32'd0, 5'd7, 2, 32'h80FF_FF7F,
               32'h0000_0100, 4'b1000, 32'd0);
        push_wb(5'd8, 32'h0000_0080);
        mem_op(1'b1, 3'b100, 32'h0000_0103, 32'd0, 5'd8, 2, 32'h80FF_FF7F,
               32'h0000_0100, 4'b1000, 32'd0);
        push_wb(5'd10, 32'hFFFF_80FF);
        mem_op(1'b1, 3'b001, 32'h0000_0102, 32'd0, 5'd10, 0, 32'h80FF_FF7F,
               32'h0000_0100, 4'b1100, 32'd0);
        push_wb(5'd11, 32'h0000_80FF);
        mem_op(1'b1, 3'b101, 32'h0000_0102, 32'd0, 5'd11, 1, 32'h80FF_FF7F,
               32'h0000_0100, 4'b1100, 32'd0);
        push_wb(5'd12, 32'h80FF_FF7F);
        mem_op(1'b1, 3'b010, 32'h0000_0100, 32'd0, 5'd12, 0, 32'h80FF_FF7F,
               32'h0000_0100, 4'b1111, 32'd0);

        // Stores: no writeback expected
        mem_op(1'b0, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 5'd0, 2, 32'd0,
               32'h0000_0200, 4'b1100, 32'hABCD_ABCD);
        mem_op(1'b0, 3'b000, 32'h0000_0001, 32'h1234_5678, 5'd0, 0, 32'd0,
               32'h0000_0000, 4'b0010, 32'h7878_7878);
        mem_op(1'b0, 3'b010, 32'h0000_0304, 32'hDEAD_BEEF, 5'd0, 1, 32'd0,
               32'h0000_0304, 4'b1111, 32'hDEAD_BEEF);

        // Misaligned and illegal funct3
        err_op(1'b1, 3'b010, 32'h0000_0101);
        tick();
        err_op(1'b1, 3'b001, 32'h0000_0103);
        tick();
        err_op(1'b1, 3'b011, 32'h0000_0000);
        tick();
        err_op(1'b0, 3'b011, 32'h0000_0000);
        tick();
        err_op(1'b0, 3'b010, 32'h0000_0302);
        tick();

        // Reset while in WAIT abandons the load
        drive(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'd0, 5'd9, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        bus.dmem_gnt = 1'b1;
        tick();
        bus.dmem_gnt = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("wrst_ready", 32'(bus.in_ready), 32'd1);
        check("wrst_req", 32'(bus.dmem_req), 32'd0);
        check("wrst_addr", bus.dmem_addr, 32'd0);
        check("wrst_wdata", bus.dmem_wdata, 32'd0);
        check("wrst_wregs_addr", 32'(bus.w_regs_addr), 32'd0);
        check("wrst_wregs_data", bus.w_regs_data, 32'd0);
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = 32'hCAFE_F00D;
        tick();
        bus.dmem_rvalid = 1'b0;
        @(negedge clk);
        check("wrst_no_wb", 32'(bus.w_regs_en), 32'd0);
        check("wrst_ready_after", 32'(bus.in_ready), 32'd1);
        tick();

        // Back-to-back ALU ops, one per cycle
        for (int i = 1; i <= 4; i++) begin
            push_wb(5'(i), 32'(i * 32'h11));
        end
        for (int i = 1; i <= 4; i++) begin
            drive(1'b0, 1'b0, 3'd0, 32'(i * 32'h11), 32'd0, 5'(i), 1'b1);
            tick();
        end
        bus.in_valid = 1'b0;

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL: clk  in  1  rising-edge clock.
REQ-002 SHALL: rst  in  1  reset, synchronous, active-low.
REQ-003 SHALL: in_valid  in  1  EX/MEM entry offered.
REQ-004 SHALL: in_ready  out  1  stage accepts entry this cycle.
REQ-005 SHALL: in_rd  in  5  destination register.
REQ-006 SHALL: in_wen  in  1  instruction writes rd.
REQ-007 SHALL: in_result  in  32  ALU result / effective address.
REQ-008 SHALL: in_load, in_store  in  1 each  memory op type, mutually exclusive.
REQ-009 SHALL: in_funct3  in  3  RV32I load/store width code.
REQ-010 SHALL: in_store_data  in  32  rs2 value for stores.
REQ-011 SHALL: dmem_req, dmem_we  out  1 each  data-memory request, write enable.
REQ-012 SHALL: dmem_addr  out  32  word address, bits [1:0] forced 0.
REQ-013 SHALL: dmem_wdata  out  32; dmem_be  out  4  store data, byte enables.
REQ-014 SHALL: dmem_gnt, dmem_rvalid  in  1 each; dmem_rdata  in  32  grant, read-data valid, read data.
REQ-015 SHALL: w_regs_en  out  1; w_regs_addr  out  5; w_regs_data  out  32  register-file write port.
REQ-016 SHALL: err_o  out  1  one-cycle pulse: misaligned access or illegal funct3.

Function
REQ-017 SHALL: FSM states IDLE, REQ, WAIT; in_ready = (state==IDLE), decoded from state only.
REQ-018 SHALL: IDLE, in_valid, no mem op -> w_regs_* registered, valid next cycle (1-cycle latency), state stays IDLE; throughput 1/cycle.
REQ-019 SHALL: w_regs_en = in_wen && rd!=0, high exactly one cycle per completed op; w_regs_addr/data hold last values when w_regs_en=0.
REQ-020 SHALL: IDLE, in_valid, legal aligned load/store -> capture entry, state REQ.
REQ-021 SHALL: REQ: dmem_req=1; addr/we/be/wdata stable until dmem_gnt; on gnt, store -> IDLE (no writeback), load -> WAIT.
REQ-022 SHALL: WAIT: on dmem_rvalid, write aligned load data next cycle, state IDLE; rvalid in IDLE/REQ ignored (earliest legal rvalid: cycle after gnt).
REQ-023 SHALL: load extraction by addr[1:0]: LB 000 / LBU 100 = sign/zero-extended byte; LH 001 / LHU 101 = halfword addr[1]; LW 010 = full word.
REQ-024 SHALL: store: SB be=4'b0001<<addr[1:0], byte replicated x4; SH be=4'b0011<<{addr[1],1'b0}, half replicated x2; SW be=4'b1111.
REQ-025 SHALL: halfword with addr[0]=1, word with addr[1:0]!=0, load funct3 in {011,110,111} or store funct3 >010 -> no dmem_req, no writeback, err_o pulse next cycle, stay IDLE.
REQ-026 SHALL: dmem_we=0 and dmem_be=4'b0000 whenever dmem_req=0.

Reset
REQ-027 SHALL: rst low at clock edge -> state IDLE; dmem_req, dmem_we, dmem_be, w_regs_en, err_o = 0; dmem_addr, dmem_wdata, w_regs_addr, w_regs_data = 0.
REQ-028 SHALL: reset during REQ/WAIT abandons the op (no writeback, later rvalid ignored); in_ready=1 the cycle after reset deasserts.

Structure
REQ-029 SHALL: shared package rv_mem_pkg holds funct3 width constants (LB..LHU, SB..SW) and the FSM state enum.
REQ-030 SHALL: combinational sub-module lsu_load_align (funct3, addr[1:0], rdata -> 32-bit result) instantiated once.

Verification
REQ-031 SHALL: ADD result 0x0000_1234, rd=5, wen=1 -> next cycle w_regs_en=1, addr=5, data=0x0000_1234; rd=0 -> w_regs_en=0.
REQ-032 SHALL: LB addr 0x103, rdata 0x80FF_FF7F, gnt after 2 wait cycles, rvalid 1 cycle later -> data 0xFFFF_FF80; LBU -> 0x0000_0080; in_ready=0 throughout.
REQ-033 SHALL: SH addr 0x202, data 0x0000_ABCD -> dmem_addr 0x200, be 4'b1100, wdata 0xABCD_ABCD, held until gnt; no writeback.
REQ-034 SHALL: LW addr 0x101 -> no dmem_req, err_o pulse 1 cycle, w_regs_en=0, in_ready stays 1.
REQ-035 SHALL: rst low while in WAIT, then rvalid -> no writeback, all outputs 0, state IDLE.
REQ-036 SHALL: back-to-back ALU ops, one per cycle for 4 cycles -> 4 consecutive w_regs_en pulses in order.
